// File: rtl/instr_fetch_pkg.sv
// Shared parameters for the instruction fetch block.
// Holds the opcode field width, the halt opcode and the fetch FSM state type.
package instr_fetch_pkg;

  localparam int OPCODE_WIDTH = 4;

  localparam logic [OPCODE_WIDTH-1:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    ISSUE = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer.
// Walks the instruction BRAM from address 0 to prog_last, presenting one
// instruction at a time to the decoder with a valid/ready handshake. A halt
// opcode or the last address ends the program, then a drain period lets the
// downstream pipeline empty before done pulses.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, abort        begin execution from address 0 / return to idle
//   prog_last           last instruction address, sampled on start
//   imem_en, imem_addr  BRAM read request (address is the pc)
//   imem_rdata          BRAM read data, valid one clock after imem_en
//   instr_out/valid     instruction to the decoder
//   instr_ready         decoder accepts instr_out this cycle
//   busy, done          not idle / one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start
// FETCH | BRAM read issued for pc
// WAIT  | BRAM data captured, halt opcode checked
// ISSUE | instruction presented until decoder accepts
// DRAIN | counting down while the pipeline empties
// DONE  | done pulse, back to IDLE
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int INSTR_WIDTH  = OPCODE_WIDTH + 3 * ADDR_WIDTH + 1,
  parameter int DRAIN_CYCLES = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDR_WIDTH-1:0]  prog_last,
  output logic                   imem_en,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] PC_MAX   = '1;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   imem_en_q, imem_en_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = '0;
          last_d  = prog_last;
          state_d = FETCH;
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        instr_d = imem_rdata;
        if (imem_rdata[INSTR_WIDTH-1 -: OPCODE_WIDTH] == OP_HALT) begin
          cnt_d   = CNT_LOAD;
          state_d = DRAIN;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          // The top address always ends the program so pc cannot wrap to 0.
          if (pc_q == last_q || pc_q == PC_MAX) begin
            cnt_d   = CNT_LOAD;
            state_d = DRAIN;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
    end

    // Outputs are decoded from the next state so they register in step with it.
    imem_en_d = (state_d == FETCH);
    valid_d   = (state_d == ISSUE);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      last_q    <= '0;
      cnt_q     <= '0;
      instr_q   <= '0;
      imem_en_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      instr_q   <= instr_d;
      imem_en_q <= imem_en_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign imem_en     = imem_en_q;
  assign imem_addr   = pc_q;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, instruction-memory address width.
REQ-002 Parameter INSTR_WIDTH, default OPCODE_WIDTH+3*ADDR_WIDTH+1, instruction word width.
REQ-003 Parameter DRAIN_CYCLES, default 6, clocks to wait after the last issue so the 3-stage half-clock pipeline empties.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse; begins program execution from address 0.
REQ-007 abort  input  1  stops execution and returns to idle; no done pulse.
REQ-008 prog_last  input  ADDR_WIDTH  address of the last instruction; sampled on accepted start.
REQ-009 imem_en  output  1  instruction BRAM read enable.
REQ-010 imem_addr  output  ADDR_WIDTH  instruction BRAM read address (= pc).
REQ-011 imem_rdata  input  INSTR_WIDTH  BRAM read data; valid one clock after imem_en.
REQ-012 instr_out  output  INSTR_WIDTH  instruction to the decoder.
REQ-013 instr_valid  output  1  instr_out holds a valid instruction.
REQ-014 instr_ready  input  1  decoder accepts instr_out this cycle.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at normal program completion.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, WAIT, ISSUE, DRAIN, DONE.
REQ-018 IDLE: start=1 -> pc<=0, prog_last latched, next FETCH; start SHALL be ignored in all other states.
REQ-019 FETCH: imem_en=1, imem_addr=pc for exactly one cycle; next WAIT.
REQ-020 WAIT: imem_rdata captured into instr_out register; if its opcode field (MSBs) equals OP_HALT, next DRAIN without issuing it; otherwise next ISSUE.
REQ-021 ISSUE: instr_valid=1; instr_out SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-022 ISSUE with instr_ready=1: if pc==prog_last, next DRAIN; else pc<=pc+1, next FETCH.
REQ-023 pc SHALL never wrap: pc==2**ADDR_WIDTH-1 is treated as last regardless of prog_last.
REQ-024 DRAIN: drain counter loads DRAIN_CYCLES-1 on entry and decrements each cycle; at 0, next DONE.
REQ-025 DONE: done=1 for one cycle; next IDLE.
REQ-026 abort=1 in any state: next IDLE, instr_valid=0 and imem_en=0 in the following cycle, no done; abort takes priority over start and instr_ready.
REQ-027 imem_en SHALL be 0 outside FETCH; instr_valid SHALL be 0 outside ISSUE.
REQ-028 Minimum instruction spacing SHALL be 3 clocks (FETCH, WAIT, ISSUE) with instr_ready held high.
REQ-029 prog_last=0 SHALL execute exactly one instruction.

Reset
REQ-030 rst=1 -> state IDLE, pc=0, drain counter=0, instr_out=0, instr_valid=0, imem_en=0, imem_addr=0, busy=0, done=0 on the next edge.
REQ-031 rst SHALL override abort, start and all other inputs; reset mid-program SHALL discard the in-flight instruction without a done pulse.

Structure
REQ-032 OPCODE_WIDTH, OP_HALT and the FSM state enum typedef SHALL live in the shared params package.
REQ-033 The block SHALL be a single module with no sub-modules; the drain counter stays inline.

Verification
REQ-034 prog_last=3, no HALT, instr_ready=1 -> addresses 0,1,2,3 issued 3 clocks apart; done pulses DRAIN_CYCLES+1 clocks after the 4th handshake.
REQ-035 instr_ready held low 5 clocks in ISSUE -> instr_out unchanged and instr_valid=1 throughout; pc advances only after ready.
REQ-036 OP_HALT at address 2, prog_last=9 -> only 0 and 1 issued; halt never presented; done follows the drain.
REQ-037 abort asserted in WAIT of address 1 -> IDLE next cycle, busy=0, no done; a subsequent start restarts at address 0.
REQ-038 rst asserted in DRAIN -> all outputs at reset values next cycle; start during busy (ISSUE) -> ignored, pc unaffected.
REQ-039 prog_last=0 -> exactly one handshake, then done; ADDR_WIDTH=4 with prog_last=15 -> 16 issues, no wrap to 0.
